// File: rtl/pwm_multi_mode.sv
// Multi-channel PWM generator: edges are computed one channel per clock into
// shadow registers and committed per channel at that channel's period wrap.
module pwm_multi_mode #(
    parameter int WIDTH  = 13,
    parameter int CH_NUM = 249
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         SYNC,
    input  logic                         UPDATE,
    input  logic                         MODE,
    input  logic [CH_NUM-1:0][WIDTH-1:0] CYCLE,
    input  logic [CH_NUM-1:0][WIDTH-1:0] DUTY,
    input  logic [CH_NUM-1:0][WIDTH-1:0] PHASE,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [CH_NUM-1:0][WIDTH-1:0] TIME_CNT,
    output logic [CH_NUM-1:0]            PWM_OUT
);
    localparam int EW    = WIDTH + 2;
    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, CALC} state_t;

    state_t           state_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             mode_reg;
    logic [IDX_W-1:0] ch_idx_reg;

    logic             s1_valid_reg;
    logic [IDX_W-1:0] s1_idx_reg;
    logic [WIDTH-1:0] s1_c_reg, s1_d_reg, s1_p_reg;

    logic             s2_valid_reg;
    logic [IDX_W-1:0] s2_idx_reg;
    logic [EW-1:0]    s2_c_reg, s2_r_reg, s2_f_reg;
    logic             s2_full_reg;

    logic [EW-1:0]    c_e, d_e, p_e, cm1_e, p_cl, d_cl, r_next, f_next;
    logic             full_next;
    logic [EW-1:0]    r_red1, r_red2, f_red;
    logic [WIDTH-1:0] sh_r, sh_f;

    // Stage 2: clamp and form unreduced edges; mode 0 R may exceed C twice over.
    always_comb begin
        c_e   = EW'(s1_c_reg);
        d_e   = EW'(s1_d_reg);
        p_e   = EW'(s1_p_reg);
        cm1_e = c_e - EW'(1);
        p_cl  = (p_e > cm1_e) ? cm1_e : p_e;
        d_cl  = (d_e > cm1_e) ? cm1_e : d_e;
        if (mode_reg) begin
            r_next    = d_cl;
            f_next    = p_cl;
            full_next = 1'b0;
        end else begin
            r_next    = (c_e << 1) - p_cl - (d_e >> 1);
            f_next    = c_e - p_cl + ((d_e + EW'(1)) >> 1);
            full_next = (d_e >= c_e);
        end
    end

    // Stage 3: modulo C by conditional subtraction.
    always_comb begin
        r_red1 = (s2_r_reg >= s2_c_reg) ? s2_r_reg - s2_c_reg : s2_r_reg;
        r_red2 = (r_red1 >= s2_c_reg) ? r_red1 - s2_c_reg : r_red1;
        f_red  = (s2_f_reg >= s2_c_reg) ? s2_f_reg - s2_c_reg : s2_f_reg;
        sh_r   = WIDTH'(r_red2);
        sh_f   = WIDTH'(f_red);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            mode_reg     <= 1'b0;
            ch_idx_reg   <= '0;
            s1_valid_reg <= 1'b0;
            s1_idx_reg   <= '0;
            s1_c_reg     <= '0;
            s1_d_reg     <= '0;
            s1_p_reg     <= '0;
            s2_valid_reg <= 1'b0;
            s2_idx_reg   <= '0;
            s2_c_reg     <= '0;
            s2_r_reg     <= '0;
            s2_f_reg     <= '0;
            s2_full_reg  <= 1'b0;
        end else begin
            s1_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            s2_valid_reg <= s1_valid_reg;
            s2_idx_reg   <= s1_idx_reg;
            s2_c_reg     <= c_e;
            s2_r_reg     <= r_next;
            s2_f_reg     <= f_next;
            s2_full_reg  <= full_next;
            case (state_reg)
                IDLE: begin
                    if (UPDATE) begin
                        mode_reg   <= MODE;
                        busy_reg   <= 1'b1;
                        ch_idx_reg <= '0;
                        state_reg  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    s1_valid_reg <= 1'b1;
                    s1_idx_reg   <= ch_idx_reg;
                    s1_c_reg     <= CYCLE[ch_idx_reg];
                    s1_d_reg     <= DUTY[ch_idx_reg];
                    s1_p_reg     <= PHASE[ch_idx_reg];
                    if (ch_idx_reg == LAST_IDX) begin
                        state_reg <= CALC;
                    end else begin
                        ch_idx_reg <= ch_idx_reg + IDX_W'(1);
                    end
                end
                CALC: begin
                    // DONE is raised one edge early so it coincides with the final shadow write.
                    if (s1_valid_reg && s1_idx_reg == LAST_IDX) begin
                        done_reg <= 1'b1;
                    end
                    if (done_reg) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign BUSY = busy_reg;
    assign DONE = done_reg;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(gi);

            logic [WIDTH-1:0] time_cnt_reg;
            logic [WIDTH-1:0] r_act_reg, f_act_reg, r_sh_reg, f_sh_reg;
            logic             full_act_reg, full_sh_reg, pending_reg, pwm_reg;
            logic             wrap, commit;

            always_comb begin
                wrap   = (time_cnt_reg >= CYCLE[gi] - WIDTH'(1));
                commit = wrap && !SYNC && pending_reg;
            end

            always_ff @(posedge CLK) begin
                if (!RST_N) begin
                    time_cnt_reg <= '0;
                    r_act_reg    <= '0;
                    f_act_reg    <= '0;
                    full_act_reg <= 1'b0;
                    r_sh_reg     <= '0;
                    f_sh_reg     <= '0;
                    full_sh_reg  <= 1'b0;
                    pending_reg  <= 1'b0;
                    pwm_reg      <= 1'b0;
                end else begin
                    if (SYNC || wrap) begin
                        time_cnt_reg <= '0;
                    end else begin
                        time_cnt_reg <= time_cnt_reg + WIDTH'(1);
                    end
                    if (commit) begin
                        r_act_reg    <= r_sh_reg;
                        f_act_reg    <= f_sh_reg;
                        full_act_reg <= full_sh_reg;
                    end
                    if (s2_valid_reg && s2_idx_reg == MY_IDX) begin
                        r_sh_reg    <= sh_r;
                        f_sh_reg    <= sh_f;
                        full_sh_reg <= s2_full_reg;
                    end
                    if (done_reg) begin
                        pending_reg <= 1'b1;
                    end else if (commit) begin
                        pending_reg <= 1'b0;
                    end
                    if (full_act_reg) begin
                        pwm_reg <= 1'b1;
                    end else if (r_act_reg < f_act_reg) begin
                        pwm_reg <= (time_cnt_reg >= r_act_reg) && (time_cnt_reg < f_act_reg);
                    end else if (f_act_reg < r_act_reg) begin
                        pwm_reg <= (time_cnt_reg >= r_act_reg) || (time_cnt_reg < f_act_reg);
                    end else begin
                        pwm_reg <= 1'b0;
                    end
                end
            end

            assign TIME_CNT[gi] = time_cnt_reg;
            assign PWM_OUT[gi]  = pwm_reg;
        end
    endgenerate
endmodule

// File: tb/tb_pwm_multi_mode.sv
// Directed plus random bench for pwm_multi_mode with a cycle-level reference
// model built from the period/edge rules using plain modulo arithmetic.
module tb_pwm_multi_mode;
    localparam int W  = 13;
    localparam int CH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n, sync, update, mode;
    logic [CH-1:0][W-1:0] cycle, duty, phase;
    logic                 busy, done;
    logic [CH-1:0][W-1:0] time_cnt;
    logic [CH-1:0]        pwm_out;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int m_t[CH];
    int m_ra[CH], m_fa[CH], m_rs[CH], m_fs[CH], m_rt[CH], m_ft[CH];
    bit m_fulla[CH], m_fulls[CH], m_fullt[CH], m_pend[CH], m_pwm[CH];
    bit m_busy, m_done, m_mode;
    int m_n;

    pwm_multi_mode #(.WIDTH(W), .CH_NUM(CH)) dut (
        .CLK(clk), .RST_N(rst_n), .SYNC(sync), .UPDATE(update), .MODE(mode),
        .CYCLE(cycle), .DUTY(duty), .PHASE(phase),
        .BUSY(busy), .DONE(done), .TIME_CNT(time_cnt), .PWM_OUT(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pwm_rule(input int t, input int r, input int f, input bit full);
        if (full) return 1'b1;
        if (r < f) return (t >= r) && (t < f);
        if (f < r) return (t >= r) || (t < f);
        return 1'b0;
    endfunction

    task automatic calc(input bit md, input int c, input int d, input int ph,
                        output int r, output int f, output bit full);
        int p;
        p = (ph > c - 1) ? c - 1 : ph;
        if (!md) begin
            full = (d >= c);
            r = full ? 0 : (2 * c - p - d / 2) % c;
            f = full ? 0 : (c - p + (d + 1) / 2) % c;
        end else begin
            full = 1'b0;
            r = (d > c - 1) ? c - 1 : d;
            f = p;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < CH; i++) begin
            m_t[i] = 0; m_ra[i] = 0; m_fa[i] = 0; m_rs[i] = 0; m_fs[i] = 0;
            m_rt[i] = 0; m_ft[i] = 0;
            m_fulla[i] = 0; m_fulls[i] = 0; m_fullt[i] = 0; m_pend[i] = 0; m_pwm[i] = 0;
        end
        m_busy = 0; m_done = 0; m_mode = 0; m_n = 0;
    endtask

    // Advances the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        bit wrap, np;
        int k;
        if (!rst_n) begin
            m_reset();
            return;
        end
        for (int i = 0; i < CH; i++) begin
            np   = pwm_rule(m_t[i], m_ra[i], m_fa[i], m_fulla[i]);
            wrap = (m_t[i] >= int'(cycle[i]) - 1);
            if (wrap && !sync && m_pend[i]) begin
                m_ra[i] = m_rs[i]; m_fa[i] = m_fs[i]; m_fulla[i] = m_fulls[i];
                m_pend[i] = 0;
            end
            m_t[i]   = (sync || wrap) ? 0 : m_t[i] + 1;
            m_pwm[i] = np;
        end
        if (m_busy) begin
            m_n++;
            if (m_n >= 1 && m_n <= CH) begin
                k = m_n - 1;
                calc(m_mode, int'(cycle[k]), int'(duty[k]), int'(phase[k]), m_rt[k], m_ft[k], m_fullt[k]);
            end
            if (m_n >= 3 && m_n <= CH + 2) begin
                k = m_n - 3;
                m_rs[k] = m_rt[k]; m_fs[k] = m_ft[k]; m_fulls[k] = m_fullt[k];
            end
            if (m_n == CH + 2) begin
                for (int i = 0; i < CH; i++) m_pend[i] = 1;
                m_busy = 0;
            end
        end else if (update) begin
            m_busy = 1; m_n = 0; m_mode = mode;
        end
        m_done = m_busy && (m_n == CH + 1);
    endtask

    task automatic step();
        logic [CH-1:0]        ep;
        logic [CH-1:0][W-1:0] et;
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            ep[i] = m_pwm[i];
            et[i] = W'(m_t[i]);
        end
        check("pwm_out", 64'(pwm_out), 64'(ep));
        check("time_cnt", 64'(time_cnt), 64'(et));
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
    endtask

    task automatic pulse_update(input bit md);
        update = 1'b1; mode = md;
        step();
        update = 1'b0;
    endtask

    task automatic wait_t(input int ch, input int val, input int limit);
        int k = 0;
        do begin
            step(); k++;
        end while (m_t[ch] != val && k < limit);
        check("wait_t_reached", 64'(time_cnt[ch]), 64'(val));
    endtask

    task automatic count_high(input int ch, input int period, input int exp_cnt, input string tag);
        int cnt = 0;
        for (int k = 0; k < period; k++) begin
            step();
            if (pwm_out[ch]) cnt++;
        end
        check(tag, 64'(cnt), 64'(exp_cnt));
        $display("phase %s: ch%0d high cycles %0d", tag, ch, cnt);
    endtask

    task automatic set_ch(input int ch, input int c, input int d, input int p);
        cycle[ch] = W'(c); duty[ch] = W'(d); phase[ch] = W'(p);
    endtask

    initial begin
        int done_cnt, busy_cnt, done_at;
        rst_n = 1'b0; sync = 1'b0; update = 1'b0; mode = 1'b0;
        for (int i = 0; i < CH; i++) set_ch(i, 100, 0, 0);
        m_reset();
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tcnt", 64'(time_cnt), 64'd0);
        check("rst_pwm", 64'(pwm_out), 64'd0);
        rst_n = 1'b1;

        // Mode 0 directed edges, full duty and zero duty
        set_ch(0, 4096, 1000, 2048);
        set_ch(1, 3000, 500, 1000);
        set_ch(2, 4096, 4096, 0);
        set_ch(3, 4096, 0, 0);
        repeat (1200) step();
        pulse_update(1'b0);
        repeat (CH + 3) step();
        wait_t(0, 0, 5000);
        step();
        count_high(0, 4096, 1000, "m0_high_cnt");
        check("m0_full_ch2", 64'(pwm_out[2]), 64'd1);
        check("m0_zero_ch3", 64'(pwm_out[3]), 64'd0);

        // Lowering the period below the current count
        wait_t(1, 2500, 4000);
        cycle[1] = W'(2000);
        step();
        check("cycle_lower_wrap", 64'(time_cnt[1]), 64'd0);
        cycle[1] = W'(3000);

        // Phase clamp: P=5000 behaves as P=4095
        set_ch(0, 4096, 1000, 5000);
        pulse_update(1'b0);
        repeat (CH + 3) step();
        wait_t(0, 0, 5000);
        step();
        count_high(0, 4096, 1000, "m0_clamp_cnt");

        // Mode 1 wrap-around edges
        set_ch(0, 4096, 3000, 100);
        pulse_update(1'b1);
        repeat (CH + 3) step();
        wait_t(0, 0, 5000);
        step();
        count_high(0, 4096, 1196, "m1_wrap_cnt");

        // Calculation timing, second UPDATE during BUSY is dropped
        done_cnt = 0; busy_cnt = 0; done_at = -1;
        for (int e = 0; e < 16; e++) begin
            update = (e == 0 || e == 3);
            mode = 1'b0;
            step();
            if (done) begin done_cnt++; done_at = e; end
            if (busy) busy_cnt++;
        end
        update = 1'b0;
        check("timing_done_cnt", 64'(done_cnt), 64'd1);
        check("timing_done_at", 64'(done_at), 64'(CH + 1));
        check("timing_busy_cnt", 64'(busy_cnt), 64'(CH + 2));
        $display("phase timing: done=%0d busy_cycles=%0d", done_cnt, busy_cnt);

        // SYNC clears every counter
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_tcnt", 64'(time_cnt), 64'd0);

        // Reset in the middle of a calculation
        pulse_update(1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        repeat (3) step();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_pwm", 64'(pwm_out), 64'd0);
        check("midrst_tcnt", 64'(time_cnt), 64'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        pulse_update(1'b1);
        for (int e = 0; e < CH + 4; e++) begin
            step();
            if (done) done_cnt++;
        end
        check("post_rst_done_cnt", 64'(done_cnt), 64'd1);

        // Randomized periods, edges, modes, syncs and updates
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < CH; i++)
                set_ch(i, $urandom_range(2, 300), $urandom_range(0, 400), $urandom_range(0, 400));
            pulse_update(1'($urandom_range(0, 1)));
            for (int k = 0; k < 300; k++) begin
                sync   = ($urandom_range(0, 199) == 0);
                update = ($urandom_range(0, 49) == 0);
                mode   = 1'($urandom_range(0, 1));
                step();
            end
            sync = 1'b0; update = 1'b0;
        end
        $display("phase random: 40 rounds complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_multi_mode.md
Name: pwm_multi_mode

Overview:
- Next-generation per-transducer PWM generator for CH_NUM channels, each with its own period CYCLE[i].
- Two modes:
  - Mode 0: centre-aligned duty/phase, as in the current generator.
  - Mode 1: explicit rise/fall edges.
- Edge computation is time-multiplexed, one channel per clock, into shadow registers. Shadow values are committed to active registers per channel at that channel's period wrap.
- Runs on a single clock. Sits between the control/modulation logic and the transducer output drivers.

Parameters:
WIDTH, 13, bit width of cycle/duty/phase/edge/time values
CH_NUM, 249, number of channels (1..1024)

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
SYNC  in  1  one-cycle pulse; forces every TIME_CNT[i] to 0 on the next edge
UPDATE  in  1  one-cycle request to recompute all channels; ignored while BUSY=1
MODE  in  1  0 = duty/phase, 1 = rise/fall; sampled with UPDATE
CYCLE  in  [WIDTH-1:0] x CH_NUM  period per channel; legal range 2..2^WIDTH-1
DUTY  in  [WIDTH-1:0] x CH_NUM  mode 0 duty; mode 1 rise edge
PHASE  in  [WIDTH-1:0] x CH_NUM  mode 0 phase; mode 1 fall edge
BUSY  out  1  calculation in progress
DONE  out  1  one-cycle pulse when the last channel's shadow is written
TIME_CNT  out  [WIDTH-1:0] x CH_NUM  per-channel period counter
PWM_OUT  out  1 x CH_NUM  registered PWM outputs

Behaviour:
- Reset (RST_N=0 at an edge):
  - TIME_CNT[i]=0, PWM_OUT[i]=0, BUSY=0, DONE=0.
  - Active and shadow R=F=0, FULL=0, pending flags cleared.
  - Reset during a calculation aborts it; no partial commit.
- Counter, per channel:
  - If SYNC=1: TIME_CNT <= 0.
  - Else if TIME_CNT >= CYCLE-1: TIME_CNT <= 0 (wrap). This covers CYCLE being lowered below the current count.
  - Else TIME_CNT increments.
  - SYNC has priority over wrap.
- Calculation, FSM IDLE -> CAPTURE -> CALC -> IDLE:
  - UPDATE high in IDLE at edge 0: MODE is latched, BUSY=1 from edge 1.
  - At edge k+1 channel k's CYCLE/DUTY/PHASE are sampled into a 2-stage pipeline.
  - At edge k+3 channel k's shadow (R, F, FULL) is written atomically.
  - DONE pulses and BUSY drops at edge CH_NUM+2, returning to IDLE.
  - On DONE all pending[i] are set.
  - UPDATE during BUSY is dropped, not queued.
- Arithmetic: WIDTH+2-bit unsigned; C=CYCLE, P=min(PHASE, C-1), D=DUTY.
  - Mode 0, FULL = (D >= C):
    - R = (2C - P - floor(D/2)) mod C, using up to two conditional subtracts of C.
    - F = (C - P + floor((D+1)/2)) mod C, using one conditional subtract.
  - Mode 1: R = min(DUTY, C-1), F = min(PHASE, C-1), FULL=0.
- Commit: at the edge where channel i wraps (TIME_CNT[i] = C-1, no SYNC) with pending[i]=1, active <= shadow and pending[i] is cleared.
  - A wrap during CALC with pending still set from the prior run may load a newer complete pair. This is legal, since pairs are written atomically.
- Output, with t = TIME_CNT[i] and PWM_OUT registered one cycle after t:
  - If FULL: high.
  - Else if R < F: high iff R <= t < F.
  - Else if F < R: high iff t >= R or t < F.
  - Else (R = F): low.

Test Plan:
- Reset: CH_NUM=4, drive RST_N=0 for 3 cycles mid-CALC -> PWM_OUT=0, TIME_CNT=0, BUSY=0, no DONE; first UPDATE after reset completes normally.
- Mode 0 edges: ch0 C=4096, D=1000, P=2048 -> R=1548, F=2548; after the first wrap following DONE, exactly 1000 high cycles per period at t in [1548,2548).
- Mode 0 limits:
  - D=4096 -> PWM_OUT constant 1.
  - D=0, P=0 -> R=F=0, constant 0.
  - P=5000 with C=4096 -> clamped to P=4095.
- Mode 1 wrap-around: C=4096, R=3000, F=100 -> high for t>=3000 or t<100, 1196 cycles per period.
- Timing: UPDATE at cycle 0 with CH_NUM=4 -> BUSY cycles 1..6, DONE only at cycle 6; second UPDATE at cycle 3 ignored, with no second DONE.
- Buffering and sync:
  - Ch1 C=3000, mid-period update -> PWM_OUT unchanged until TIME_CNT wraps at 2999.
  - SYNC pulse -> all TIME_CNT=0 next cycle with no commit.
  - Lowering CYCLE to 2000 while TIME_CNT=2500 -> wrap to 0 next cycle.
